// File: rtl/victim_drain.sv
// victim_drain: background writeback engine for the fully associative victim
// cache. While the controller is idle it copies valid+dirty victim lines to
// physical memory, then has the controller rewrite the way unchanged with the
// dirty bit cleared.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   way_valid/way_dirty   per-way status bits
//   way_tag/way_line      per-way stored tag and line (way i at slice i)
//   busy_in               controller owns the ways this cycle (honoured in IDLE)
//   flush_req             write back every dirty line, then pulse flush_done
//   drain_active          engine owns the ways (WRITE/CLEAN)
//   clean_way             one-hot way rewrite with dirty=0
//   pmem_write/address/wdata, pmem_resp   physical memory write port
//   flush_done            one-cycle pulse at flush completion
//   wb_count              saturating count of completed writebacks

// Per-way slice: candidate detect and clean strobe decode.
module victim_drain_way #(
  parameter int WAY_IDX = 0,
  parameter int IDX_W   = 2
) (
  input  logic             valid,
  input  logic             dirty,
  input  logic [IDX_W-1:0] sel_idx,
  input  logic             in_clean,
  output logic             cand,
  output logic             clean
);
  assign cand  = valid & dirty;
  assign clean = in_clean & (sel_idx == IDX_W'(WAY_IDX));
endmodule

module victim_drain #(
  parameter int NUM_WAYS     = 4,
  parameter int TAG_WIDTH    = 12,
  parameter int LINE_WIDTH   = 128,
  parameter int DRAIN_THRESH = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_WAYS-1:0]            way_valid,
  input  logic [NUM_WAYS-1:0]            way_dirty,
  input  logic [NUM_WAYS*TAG_WIDTH-1:0]  way_tag,
  input  logic [NUM_WAYS*LINE_WIDTH-1:0] way_line,
  input  logic                           busy_in,
  input  logic                           flush_req,
  output logic                           drain_active,
  output logic [NUM_WAYS-1:0]            clean_way,
  output logic                           pmem_write,
  output logic [15:0]                    pmem_address,
  output logic [LINE_WIDTH-1:0]          pmem_wdata,
  input  logic                           pmem_resp,
  output logic                           flush_done,
  output logic [15:0]                    wb_count
);
  localparam int IDX_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int CNT_W = $clog2(NUM_WAYS + 1);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(DRAIN_THRESH);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAN, DONE} state_t;

  // Transfer snapshot taken at the start decision; memory sees only this.
  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic [TAG_WIDTH-1:0]  tag;
    logic [LINE_WIDTH-1:0] line;
  } snap_t;

  state_t state, state_nxt;
  snap_t  snap;
  logic   flush_pending;
  logic   start, in_clean, found;

  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0]  tags;
  logic [NUM_WAYS-1:0][LINE_WIDTH-1:0] lines;
  logic [NUM_WAYS-1:0]                 cand;
  logic [IDX_W-1:0]                    sel_idx;
  logic [CNT_W-1:0]                    dcount;

  assign tags  = way_tag;
  assign lines = way_line;

  for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way
    victim_drain_way #(.WAY_IDX(i), .IDX_W(IDX_W)) u_way (
      .valid    (way_valid[i]),
      .dirty    (way_dirty[i]),
      .sel_idx  (snap.idx),
      .in_clean (in_clean),
      .cand     (cand[i]),
      .clean    (clean_way[i])
    );
  end

  // Lowest-index candidate wins: scan high to low so the last hit sticks.
  always_comb begin
    sel_idx = '0;
    dcount  = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (cand[i]) sel_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_WAYS; i++) begin
      dcount = dcount + CNT_W'(cand[i]);
    end
  end

  assign found = |cand;

  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    in_clean     = 1'b0;
    pmem_write   = 1'b0;
    drain_active = 1'b0;
    flush_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!busy_in) begin
          if (found && (dcount >= THRESH || flush_pending)) begin
            start     = 1'b1;
            state_nxt = WRITE;
          end else if (flush_pending && !found) begin
            state_nxt = DONE;
          end
        end
      end
      WRITE: begin
        pmem_write   = 1'b1;
        drain_active = 1'b1;
        if (pmem_resp) state_nxt = CLEAN;
      end
      CLEAN: begin
        in_clean     = 1'b1;
        drain_active = 1'b1;
        state_nxt    = IDLE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      snap          <= '0;
      flush_pending <= 1'b0;
      wb_count      <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        snap.idx  <= sel_idx;
        snap.tag  <= tags[sel_idx];
        snap.line <= lines[sel_idx];
      end
      // A request landing in DONE re-arms; it is not swallowed by the clear.
      flush_pending <= flush_req | (flush_pending & (state != DONE));
      if (in_clean && wb_count != 16'hFFFF) wb_count <= wb_count + 16'd1;
    end
  end

  assign pmem_address = 16'({snap.tag, 4'h0});
  assign pmem_wdata   = snap.line;

endmodule

// File: tb/tb_victim_drain.sv
module tb_victim_drain;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   valid, dirty, v2, d2;
  logic [47:0]  tags;
  logic [511:0] lines;
  logic         busy, flush1, flush2, resp1, resp2;

  logic         da1, pw1, fd1, da2, pw2, fd2;
  logic [3:0]   cw1, cw2;
  logic [15:0]  addr1, addr2, wb1, wb2;
  logic [127:0] wd1, wd2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  victim_drain #(.DRAIN_THRESH(1)) u1 (
    .clk(clk), .reset_n(reset_n), .way_valid(valid), .way_dirty(dirty),
    .way_tag(tags), .way_line(lines), .busy_in(busy), .flush_req(flush1),
    .drain_active(da1), .clean_way(cw1), .pmem_write(pw1),
    .pmem_address(addr1), .pmem_wdata(wd1), .pmem_resp(resp1),
    .flush_done(fd1), .wb_count(wb1));

  victim_drain #(.DRAIN_THRESH(2)) u2 (
    .clk(clk), .reset_n(reset_n), .way_valid(v2), .way_dirty(d2),
    .way_tag(tags), .way_line(lines), .busy_in(busy), .flush_req(flush2),
    .drain_active(da2), .clean_way(cw2), .pmem_write(pw2),
    .pmem_address(addr2), .pmem_wdata(wd2), .pmem_resp(resp2),
    .flush_done(fd2), .wb_count(wb2));

  function automatic logic [127:0] line_of(input int i);
    return {32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i),
            32'h3333_0000 + 32'(i), 32'h4444_0000 + 32'(i)};
  endfunction

  function automatic logic [11:0] tag_of(input int i);
    logic [47:0] t;
    t = {12'h333, 12'hABC, 12'h222, 12'h111};
    return t[i*12 +: 12];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  dirty;
    logic        busy;
    logic        resp;
    logic        pw;
    logic        da;
    logic [3:0]  cw;
    logic [15:0] wb;
    int          way;   // -1: no address/data check
  } vec_t;

  vec_t vecs[13];

  initial begin
    // dirty, busy, resp | pmem_write, drain_active, clean_way, wb_count, way
    vecs[0]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1, -1};
    vecs[1]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1, -1};
    vecs[2]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1, -1};
    vecs[3]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1, -1};
    vecs[4]  = '{4'b1110, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 16'd1, 1};
    vecs[5]  = '{4'b1110, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 16'd1, 1};
    vecs[6]  = '{4'b1110, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 16'd1, -1};
    vecs[7]  = '{4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd2, -1};
    vecs[8]  = '{4'b1100, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 16'd2, 3};
    vecs[9]  = '{4'b1100, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 16'd2, -1};
    vecs[10] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd3, -1};
    vecs[11] = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 16'd3, -1};
    vecs[12] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd3, -1};

    tags = {12'h333, 12'hABC, 12'h222, 12'h111};
    for (int i = 0; i < 4; i++) lines[i*128 +: 128] = line_of(i);
    reset_n = 1'b0; busy = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    resp1 = 1'b0; resp2 = 1'b0; v2 = 4'b0; d2 = 4'b0;
    valid = 4'b0100; dirty = 4'b0100;

    // Reset state with way 2 dirty waiting.
    #22;
    chk("rst_pw", pw1, 1'b0);
    chk("rst_da", da1, 1'b0);
    chk("rst_cw", cw1, 4'b0);
    chk("rst_addr", addr1, 16'h0);
    chk("rst_wdata", wd1, 128'h0);
    chk("rst_fd", fd1, 1'b0);
    chk("rst_wb", wb1, 16'h0);

    @(negedge clk); reset_n = 1'b1;
    step();
    chk("t1_pw", pw1, 1'b1);
    chk("t1_da", da1, 1'b1);
    chk("t1_addr", addr1, 16'hABC0);
    chk("t1_wdata", wd1, line_of(2));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_hold_pw", pw1, 1'b1);
    end
    resp1 = 1'b1; step();
    chk("t1_cw", cw1, 4'b0100);
    chk("t1_clean_pw", pw1, 1'b0);
    resp1 = 1'b0; dirty = 4'b0000; step();
    chk("t1_cw_off", cw1, 4'b0000);
    chk("t1_wb", wb1, 16'd1);

    // Table: busy gating, lowest-index order, invalid-dirty skip, stray resp.
    valid = 4'b1011;
    for (int i = 0; i < 13; i++) begin
      dirty = vecs[i].dirty; busy = vecs[i].busy; resp1 = vecs[i].resp;
      step();
      chk($sformatf("v%0d_pw", i), pw1, vecs[i].pw);
      chk($sformatf("v%0d_da", i), da1, vecs[i].da);
      chk($sformatf("v%0d_cw", i), cw1, vecs[i].cw);
      chk($sformatf("v%0d_wb", i), wb1, vecs[i].wb);
      chk($sformatf("v%0d_fd", i), fd1, 1'b0);
      if (vecs[i].way >= 0) begin
        chk($sformatf("v%0d_addr", i), addr1, {tag_of(vecs[i].way), 4'h0});
        chk($sformatf("v%0d_wdata", i), wd1, line_of(vecs[i].way));
      end
    end
    busy = 1'b0; resp1 = 1'b0;

    // Snapshot: ways change during WRITE, transfer must not.
    valid = 4'b0001; dirty = 4'b0001;
    step();
    chk("snap_pw", pw1, 1'b1);
    tags[11:0] = 12'hFFF; lines[127:0] = ~line_of(0);
    step();
    chk("snap_addr", addr1, 16'h1110);
    chk("snap_wdata", wd1, line_of(0));
    resp1 = 1'b1; step();
    chk("snap_cw", cw1, 4'b0001);
    resp1 = 1'b0; dirty = 4'b0000; step();
    chk("snap_wb", wb1, 16'd4);
    tags[11:0] = 12'h111; lines[127:0] = line_of(0);

    // Reset mid-WRITE abandons the transfer; the line drains again after.
    dirty = 4'b0001;
    step();
    chk("mrst_pw_before", pw1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_pw", pw1, 1'b0);
    chk("mrst_da", da1, 1'b0);
    chk("mrst_wb", wb1, 16'd0);
    @(negedge clk); reset_n = 1'b1;
    step();
    chk("mrst_redrain_pw", pw1, 1'b1);
    chk("mrst_redrain_addr", addr1, 16'h1110);
    resp1 = 1'b1; step();
    chk("mrst_cw", cw1, 4'b0001);
    resp1 = 1'b0; dirty = 4'b0000; step();
    chk("mrst_wb", wb1, 16'd1);

    // Threshold 2, one dirty way: no drain until a flush.
    v2 = 4'b0010; d2 = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("th_idle_pw", pw2, 1'b0);
    end
    flush2 = 1'b1; step(); flush2 = 1'b0;
    chk("fl_latch_pw", pw2, 1'b0);
    step();
    chk("fl_pw", pw2, 1'b1);
    chk("fl_addr", addr2, 16'h2220);
    resp2 = 1'b1; step();
    chk("fl_cw", cw2, 4'b0010);
    chk("fl_fd_clean", fd2, 1'b0);
    resp2 = 1'b0; d2 = 4'b0000; step();
    chk("fl_idle_fd", fd2, 1'b0);
    chk("fl_idle_da", da2, 1'b0);
    chk("fl_wb", wb2, 16'd1);
    step();
    chk("fl_done", fd2, 1'b1);
    chk("fl_done_da", da2, 1'b0);
    step();
    chk("fl_done_off", fd2, 1'b0);
    // Pending must be clear: a lone dirty way stays put again.
    d2 = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fl_after_pw", pw2, 1'b0);
      chk("fl_after_fd", fd2, 1'b0);
    end

    // Flush with nothing dirty: pulse two cycles after flush_req is sampled.
    d2 = 4'b0000;
    flush2 = 1'b1; step(); flush2 = 1'b0;
    chk("fe_fd_1", fd2, 1'b0);
    step();
    chk("fe_fd_2", fd2, 1'b1);
    chk("fe_pw", pw2, 1'b0);
    step();
    chk("fe_fd_3", fd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/victim_drain.md
# victim_drain

Background writeback engine for the 4-way fully associative victim cache. During idle cycles it finds valid dirty victim lines, copies each one to physical memory, then clears its dirty bit. To clear the bit it issues a way write with the data/tag input mux held on the stored value, so data and tag are rewritten unchanged. It sits beside the victim cache controller, which owns the ways during L1 traffic, and shares the physical-memory write port with it.

## Interface
- NUM_WAYS, 4, number of victim ways scanned
- TAG_WIDTH, 12, victim tag width (line address bits [15:4])
- LINE_WIDTH, 128, cache line width
- DRAIN_THRESH, 1, minimum count of valid and dirty ways before an idle drain starts (1..NUM_WAYS)
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- way_valid  in  NUM_WAYS  per-way isValid
- way_dirty  in  NUM_WAYS  per-way isDirty
- way_tag  in  NUM_WAYS*TAG_WIDTH  per-way stored tag (pmem_base); way i at [i*TAG_WIDTH +: TAG_WIDTH]
- way_line  in  NUM_WAYS*LINE_WIDTH  per-way line_out
- busy_in  in  1  controller is using the ways this cycle
- flush_req  in  1  request to write back every dirty line
- drain_active  out  1  engine owns the ways; controller must not raise busy_in while high
- clean_way  out  NUM_WAYS  one-hot way write: controller drives write=1, datainmux_sel=1, valid_data=1, dirty_data=0 to that way
- pmem_write  out  1  physical memory write request
- pmem_address  out  16  {tag, 4'b0}
- pmem_wdata  out  LINE_WIDTH  snapshot line
- pmem_resp  in  1  memory write complete
- flush_done  out  1  one-cycle pulse: flush finished
- wb_count  out  16  saturating count of completed writebacks

## Operation
- Candidate: a way that is both valid and dirty. The selected way is the lowest-index candidate. dcount is the number of candidates.
- States: IDLE, WRITE, CLEAN, DONE.
- IDLE → WRITE when all of the following hold:
  - busy_in = 0
  - at least one candidate exists
  - dcount ≥ DRAIN_THRESH, or flush_pending = 1
- On the IDLE → WRITE transition, register the selected index, its tag and its line. pmem_address and pmem_wdata come from these registers, so later changes to the ways cannot alter the transfer.
- WRITE: pmem_write = 1, address and data held stable. Move to CLEAN on the cycle pmem_resp = 1 is sampled.
- CLEAN: clean_way = one-hot of the selected index for exactly one cycle, then IDLE. wb_count increments, saturating at 16'hFFFF.
- flush_pending:
  - Set when flush_req = 1 is sampled; flush_req is level- or pulse-tolerant.
  - While set, DRAIN_THRESH is ignored.
- IDLE → DONE when flush_pending = 1, busy_in = 0 and there are no candidates. DONE pulses flush_done, clears flush_pending, then returns to IDLE.
- drain_active = 1 in WRITE and CLEAN; 0 in IDLE and DONE.
- busy_in is only honoured in IDLE. Once WRITE is entered, the transfer always runs to completion.
- An invalid dirty way is never written back.

## Timing
- Reset, asynchronous:
  - state = IDLE; flush_pending = 0; wb_count = 0.
  - All outputs 0, including the pmem_address and pmem_wdata registers.
  - An in-flight WRITE is abandoned. The line stays dirty and is drained again later.
- Start decision made in cycle N (IDLE): pmem_write and drain_active are high from cycle N+1.
- pmem_resp sampled high in cycle M: clean_way pulses in M+1, IDLE in M+2, next start decision no earlier than M+2.
- Minimum period per line (pmem_resp high on the first WRITE cycle): 3 cycles.
- busy_in = 1 together with an eligible start: no start; the controller wins.
- flush_req arriving during WRITE or CLEAN: latched and serviced after the current line.
- flush_req with no candidates and busy_in = 0: flush_done two cycles after flush_req is sampled (IDLE → DONE, pulse).
- pmem_resp outside WRITE is ignored.

## Test plan
- Reset with way 2 valid and dirty, tag 12'hABC, busy_in = 0:
  - WRITE next cycle with pmem_address 16'hABC0 and pmem_wdata = way 2 line.
  - pmem_resp after 5 cycles → clean_way = 4'b0100 for one cycle; wb_count = 1.
- Ways 1 and 3 dirty, DRAIN_THRESH = 1: way 1 is drained first, then way 3. The two clean_way pulses occur in separate CLEAN visits.
- DRAIN_THRESH = 2 with one dirty way: no drain. Assert flush_req → the line drains, then flush_done pulses once; flush_pending is 0 afterwards.
- busy_in held high while ways are dirty: pmem_write stays 0. Drop busy_in → WRITE next cycle. Raise busy_in mid-WRITE → the transfer still completes.
- Change way_line and way_tag during WRITE: pmem_address and pmem_wdata stay at the snapshot values.
- Deassert reset_n mid-WRITE: pmem_write = 0 immediately and wb_count = 0. After release, the same dirty way is drained again.
